text_screen_buffer: RTL and testbench
=====================================

TEXT_SCREEN_BUFFER -- requirements
Module: text_screen_buffer

Interface
REQ-001 SHALL have parameter COLS, default 16: character columns per row; power of two.
REQ-002 SHALL have parameter ROWS, default 16: character rows; power of two.
REQ-003 SHALL have parameter CODE_W, default 7: character code width.
REQ-004 SHALL have parameter NUM_DIGITS, default 4: decimal digits printed by the number engine.
REQ-005 SHALL have parameter NUM_W, default 14: binary width of the number input.
REQ-006 SHALL have parameter BLANK, default 7'h00: code written by clear and leading-zero blanking.
REQ-007 SHALL have parameter LZ_BLANK, default 1: 1 = leading zeros printed as BLANK.
REQ-008 SHALL use derived widths ADDR_W = log2(ROWS)+log2(COLS) and CELLS = ROWS*COLS; cell index = {row, col}.
REQ-009 SHALL use one clock and an asynchronous, active-low reset.
REQ-010 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-011 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-012 SHALL have port rd_yx  in  ADDR_W  read cell index.
REQ-013 SHALL have port rd_code  out  CODE_W  registered code of cell rd_yx.
REQ-014 SHALL have port wr_valid  in  1  single-cell write request.
REQ-015 SHALL have port wr_ready  out  1  high in IDLE only.
REQ-016 SHALL have ports wr_yx  in  ADDR_W and wr_code  in  CODE_W: write target cell and code.
REQ-017 SHALL have port clr_req  in  1  one-cycle pulse requesting a full-screen clear.
REQ-018 SHALL have port num_valid  in  1  number print request.
REQ-019 SHALL have port num_ready  out  1  = IDLE and not clr_req and no clear pending.
REQ-020 SHALL have ports num_value  in  NUM_W and num_yx  in  ADDR_W: binary value and most-significant-digit cell.
REQ-021 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-022 SHALL hold a CELLS x CODE_W storage array with at most one array write per cycle.
REQ-023 SHALL update rd_code one cycle after rd_yx is presented (latency 1), always, in every state.
REQ-024 SHALL return old contents on a read of a cell written in the same cycle (read-before-write).
REQ-025 SHALL implement FSM states IDLE, CLEAR, CONVERT, PRINT.
REQ-026 SHALL write wr_code to wr_yx on wr_valid and wr_ready, in that cycle.
REQ-027 SHALL, in IDLE, give priority pending-clear/clr_req > num handshake; a write accepted in the same cycle still completes and a following clear then overwrites it.
REQ-028 SHALL, in CLEAR, write BLANK to index 0,1,...,CELLS-1, one per cycle, then enter IDLE; duration exactly CELLS cycles.
REQ-029 SHALL, on clr_req outside IDLE, set a single pending bit (further pulses merge); on return to IDLE the clear starts next cycle, before any num/wr acceptance.
REQ-030 SHALL, on num handshake, capture num_yx and min(num_value, 10^NUM_DIGITS-1) (saturation), then enter CONVERT.
REQ-031 SHALL, in CONVERT, run sequential double-dabble (add-3 where digit >= 5, then shift) for exactly NUM_W cycles, then enter PRINT.
REQ-032 SHALL, in PRINT, write NUM_DIGITS cells, one per cycle, MSD first, at num_yx, num_yx+1, ...; code = 7'h30 + digit.
REQ-033 SHALL, with LZ_BLANK=1, write BLANK for leading zeros; the least-significant digit always prints '0'..'9'.
REQ-034 SHALL increment cell index modulo CELLS (last cell wraps to 0; row overflow flows into next row).
REQ-035 SHALL make total number latency from the acceptance cycle T: CONVERT T+1..T+NUM_W, PRINT T+NUM_W+1..T+NUM_W+NUM_DIGITS, IDLE at T+NUM_W+NUM_DIGITS+1.
REQ-036 SHALL ignore num_valid and wr_valid while busy; the requester holds them (valid/ready).

Reset
REQ-037 SHALL, on rst_n low, force rd_code=0, pending clear=0, BCD and counters=0, and state CLEAR with sweep index 0, asynchronously, mid-operation included.
REQ-038 SHALL, after rst_n release, clear the whole array (CELLS cycles, busy=1) before the first write is accepted.

Verification
REQ-039 SHALL cover release reset, then read all 256 cells -> every rd_code = 0x00; busy low exactly 256 cycles after release.
REQ-040 SHALL cover write 0x47 to 0x24, read 0x24 same cycle then next -> old 0x00 then 0x47, each one cycle after the address.
REQ-041 SHALL cover num_value=307, num_yx=0x4B -> cells 0x4B..0x4E = 00,33,30,37; IDLE 19 cycles after acceptance.
REQ-042 SHALL cover num_value=16383, num_yx=0xFE -> 0xFE,0xFF,0x00,0x01 = 39,39,39,39 (saturate and wrap).
REQ-043 SHALL cover clr_req during PRINT -> print completes, then 256-cycle clear; num_ready low until IDLE; all cells 0x00.
REQ-044 SHALL cover rst_n low mid-CONVERT -> rd_code=0 immediately, busy=1, full clear restarts at index 0 after release.

Source files
------------

// File: rtl/text_screen_buffer.sv
// text_screen_buffer: character cell store with single-cell writes, a
// full-screen clear sweep and a binary-to-decimal number printer.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_yx -> rd_code            registered read, latency 1, read-before-write
//   wr_valid/wr_ready/wr_yx/wr_code          single-cell write (IDLE only)
//   clr_req                     one-cycle clear pulse (held pending while busy)
//   num_valid/num_ready/num_value/num_yx     print NUM_DIGITS decimal digits
//   busy                        high whenever the engine is not IDLE
module text_screen_buffer #(
  parameter int unsigned       COLS       = 16,
  parameter int unsigned       ROWS       = 16,
  parameter int unsigned       CODE_W     = 7,
  parameter int unsigned       NUM_DIGITS = 4,
  parameter int unsigned       NUM_W      = 14,
  parameter logic [CODE_W-1:0] BLANK      = '0,
  parameter bit                LZ_BLANK   = 1'b1,
  localparam int unsigned      ADDR_W     = $clog2(ROWS) + $clog2(COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_yx,
  output logic [CODE_W-1:0] rd_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_yx,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              clr_req,
  input  logic              num_valid,
  output logic              num_ready,
  input  logic [NUM_W-1:0]  num_value,
  input  logic [ADDR_W-1:0] num_yx,
  output logic              busy
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_W + NUM_DIGITS + 1);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned NUM_MAX = pow10(NUM_DIGITS) - 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLEAR   = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;
  localparam logic [1:0] PRINT   = 2'd3;

  logic [CODE_W-1:0] mem [CELLS];

  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NUM_W-1:0]  bin, bin_n;
  logic [BCD_W-1:0]  bcd, bcd_n, bcd_adj;
  logic              pend, pend_n;
  logic              seen, seen_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [CODE_W-1:0] wdata;
  logic [3:0]        digit;
  logic              last_dig;

  assign wr_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign num_ready = (state == IDLE) && !clr_req && !pend;

  // State and datapath registers; reset lands in CLEAR so the array is swept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= '0;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      pend  <= 1'b0;
      seen  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      bin   <= bin_n;
      bcd   <= bcd_n;
      pend  <= pend_n;
      seen  <= seen_n;
    end
  end

  // Next-state, datapath and the single array write port.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    bin_n    = bin;
    bcd_n    = bcd;
    pend_n   = pend;
    seen_n   = seen;
    we       = 1'b0;
    waddr    = idx;
    wdata    = BLANK;
    digit    = bcd[BCD_W-1 -: 4];
    last_dig = (cnt == CNT_W'(NUM_DIGITS - 1));
    bcd_adj  = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Clear requests arriving while busy merge into one pending bit.
    if (state != IDLE && clr_req) pend_n = 1'b1;

    case (state)
      IDLE: begin
        if (wr_valid) begin
          we    = 1'b1;
          waddr = wr_yx;
          wdata = wr_code;
        end
        if (pend || clr_req) begin
          state_n = CLEAR;
          idx_n   = '0;
          pend_n  = 1'b0;
        end else if (num_valid) begin
          state_n = CONVERT;
          idx_n   = num_yx;
          cnt_n   = '0;
          bcd_n   = '0;
          seen_n  = 1'b0;
          bin_n   = (32'(num_value) > NUM_MAX) ? NUM_W'(NUM_MAX) : num_value;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        idx_n = idx + 1'b1;
        if (idx == ADDR_W'(CELLS - 1)) state_n = IDLE;
      end
      CONVERT: begin
        // Double-dabble: add 3 to digits >= 5, then shift one binary bit in.
        {bcd_n, bin_n} = {bcd_adj, bin} << 1;
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(NUM_W - 1)) begin
          state_n = PRINT;
          cnt_n   = '0;
        end
      end
      default: begin
        // PRINT: emit the MSD nibble, blanking leading zeros except the LSD.
        we     = 1'b1;
        seen_n = seen || (digit != 4'd0);
        if (!(LZ_BLANK && !seen && digit == 4'd0 && !last_dig))
          wdata = CODE_W'(7'h30) + CODE_W'(digit);
        bcd_n = bcd << 4;
        idx_n = idx + 1'b1;
        cnt_n = cnt + 1'b1;
        if (last_dig) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
    endcase
  end

  // Storage array; contents are initialised by the reset clear sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; sees the pre-write value of a cell written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_code <= '0;
    else        rd_code <= mem[rd_yx];
  end

endmodule

// File: tb/tb_text_screen_buffer.sv
// tb_text_screen_buffer: directed and randomized checks of text_screen_buffer
// against a cell-array reference model computed with plain decimal arithmetic.
module tb_text_screen_buffer;
  localparam int unsigned CELLS = 256;
  localparam int unsigned NW    = 14;
  localparam int unsigned ND    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rd_yx = '0;
  logic [6:0] rd_code;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_yx = '0;
  logic [6:0] wr_code = '0;
  logic       clr_req = 1'b0;
  logic       num_valid = 1'b0;
  logic       num_ready;
  logic [13:0] num_value = '0;
  logic [7:0] num_yx = '0;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] mdl [CELLS];

  always #5 clk = ~clk;

  text_screen_buffer dut (
    .clk(clk), .rst_n(rst_n), .rd_yx(rd_yx), .rd_code(rd_code),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_yx(wr_yx), .wr_code(wr_code),
    .clr_req(clr_req), .num_valid(num_valid), .num_ready(num_ready),
    .num_value(num_value), .num_yx(num_yx), .busy(busy)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int unsigned a, output int unsigned v);
    rd_yx = 8'(a);
    tick();
    v = 32'(rd_code);
  endtask

  task automatic check_cells(input string tag, input int unsigned base, input int unsigned n);
    int unsigned v;
    for (int unsigned k = 0; k < n; k++) begin
      read_cell((base + k) % CELLS, v);
      chk(tag, v, 32'(mdl[(base + k) % CELLS]));
    end
  endtask

  task automatic wait_idle(input string tag, input int unsigned exp);
    int unsigned n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
  endtask

  task automatic mdl_clear();
    for (int unsigned i = 0; i < CELLS; i++) mdl[i] = 7'h00;
  endtask

  // Decimal rendering of min(v, 9999) with leading-zero blanking.
  task automatic mdl_num(input int unsigned v, input int unsigned yx);
    int unsigned p = 1000;
    int unsigned d;
    bit seen = 1'b0;
    if (v > 9999) v = 9999;
    for (int unsigned k = 0; k < ND; k++) begin
      d = (v / p) % 10;
      p = p / 10;
      if (!seen && d == 0 && k != ND - 1) mdl[(yx + k) % CELLS] = 7'h00;
      else begin
        mdl[(yx + k) % CELLS] = 7'(8'h30 + d);
        seen = 1'b1;
      end
    end
  endtask

  task automatic do_wr(input int unsigned a, input int unsigned c);
    chk("wr_ready", 32'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_yx    = 8'(a);
    wr_code  = 7'(c);
    tick();
    wr_valid = 1'b0;
    mdl[a % CELLS] = 7'(c);
  endtask

  task automatic do_num(input int unsigned v, input int unsigned yx);
    chk("num_ready", 32'(num_ready), 1);
    num_valid = 1'b1;
    num_value = 14'(v);
    num_yx    = 8'(yx);
    tick();
    num_valid = 1'b0;
    mdl_num(v, yx);
    wait_idle("num_latency", NW + ND);
  endtask

  task automatic do_clr();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    mdl_clear();
    wait_idle("clr_latency", CELLS);
  endtask

  initial begin
    int unsigned v, a, c, r, n;
    mdl_clear();

    // Reset and power-up clear sweep.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_rd_code", 32'(rd_code), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    rst_n = 1'b1;
    wait_idle("init_clear_len", CELLS);
    check_cells("init_cells", 0, CELLS);

    // Read-before-write on the same cell.
    chk("wr_ready_idle", 32'(wr_ready), 1);
    rd_yx    = 8'h24;
    wr_valid = 1'b1;
    wr_yx    = 8'h24;
    wr_code  = 7'h47;
    tick();
    wr_valid = 1'b0;
    chk("rbw_old", 32'(rd_code), 0);
    tick();
    chk("rbw_new", 32'(rd_code), 32'h47);
    mdl[8'h24] = 7'h47;

    // Number printing: blanking, saturation, wrap.
    do_num(307, 8'h4B);
    check_cells("num_307", 8'h4B, ND);
    do_num(16383, 8'hFE);
    check_cells("num_sat_wrap", 8'hFE, ND);

    // Randomized mix of writes, numbers and clears.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 10);
      a = $urandom_range(0, CELLS - 1);
      if (r < 5) begin
        c = $urandom_range(0, 127);
        do_wr(a, c);
        check_cells("rnd_wr", a, 1);
      end else if (r < 10) begin
        v = (r == 9) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
        do_num(v, a);
        check_cells("rnd_num", a, ND);
      end else begin
        do_clr();
        check_cells("rnd_clr", a, 8);
      end
      check_cells("rnd_other", $urandom_range(0, CELLS - 1), 2);
    end

    // Asynchronous reset in the middle of CONVERT.
    do_wr(8'h10, 8'h55);
    num_valid = 1'b1;
    num_value = 14'd42;
    num_yx    = 8'h80;
    tick();
    num_valid = 1'b0;
    rd_yx = 8'h10;
    tick();
    tick();
    chk("pre_rst_rd", 32'(rd_code), 32'h55);
    chk("pre_rst_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rd_code", 32'(rd_code), 0);
    chk("midrst_busy", 32'(busy), 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int unsigned k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) chk("sweep_before_0x10", 32'(rd_code), 32'h55);
      if (k == 18) chk("sweep_after_0x10", 32'(rd_code), 0);
    end
    mdl_clear();
    wait_idle("rst_clear_rest", CELLS - 18);
    check_cells("rst_cells", 0, CELLS);

    // Clear requested during PRINT: print finishes, then a full clear.
    do_wr(8'h03, 8'h11);
    num_valid = 1'b1;
    num_value = 14'd1234;
    num_yx    = 8'h00;
    tick();
    num_valid = 1'b0;
    for (int unsigned k = 1; k <= 15; k++) tick();
    clr_req = 1'b1;
    chk("print_num_ready", 32'(num_ready), 0);
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    chk("pend_idle_busy", 32'(busy), 0);
    chk("pend_idle_num_ready", 32'(num_ready), 0);
    n = 18;
    while (!num_ready && n < 2000) begin
      tick();
      n++;
    end
    chk("pend_clear_end", n, NW + ND + 1 + CELLS);
    chk("pend_clear_busy", 32'(busy), 0);
    mdl_clear();
    check_cells("pend_cells", 0, CELLS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
